// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX register port between NREQ byte requesters.
// Optional transfer watchdog and sticky error flag enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
  parameter int          NREQ     = 4,
  parameter logic [31:0] BAUD_DIV = 32'h1B8,
  parameter logic        RX_EN    = 1'b0,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [8*NREQ-1:0]   req_data_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic                uart_we_o,
  output logic [31:0]         uart_addr_o,
  output logic [31:0]         uart_wdata_o,
  input  logic [31:0]         uart_rdata_i,
  output logic                busy_o,
  output logic [15:0]         tx_count_o,
  output logic                err_o,
  input  logic                err_clr_i
);

  // state       | meaning
  // S_INIT_BAUD | write BAUD_DIV to BAUD
  // S_INIT_CTRL | write enable bits to CTRL
  // S_IDLE      | read STATUS, wait for any requester, pick round-robin winner
  // S_POLL      | read STATUS until UART not busy
  // S_WRITE     | write latched byte to TXDATA
  // S_CONFIRM   | read STATUS; busy means byte taken, else rewrite
  // S_ACK       | one-cycle ready pulse to the granted requester

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_BAUD   = 32'h08;
  localparam logic [31:0] A_TXDATA = 32'h0C;

  typedef enum logic [2:0] {
    S_INIT_BAUD,
    S_INIT_CTRL,
    S_IDLE,
    S_POLL,
    S_WRITE,
    S_CONFIRM,
    S_ACK
  } state_t;

  typedef struct packed {
    logic        busy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  state_t          state;
  bus_t            bus_q;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   last_grant;
  logic [7:0]      byte_q;
  logic            tmo_hit;
  logic [IW-1:0]   pick;
  logic [7:0]      pick_byte;

  // Register-port values for the cycle spent in state s.
  function automatic bus_t bus_for(input state_t s, input logic [7:0] b);
    bus_t r;
    r.busy  = (s != S_IDLE);
    r.we    = 1'b0;
    r.addr  = A_STATUS;
    r.wdata = 32'h0;
    case (s)
      S_INIT_BAUD: begin
        r.we    = 1'b1;
        r.addr  = A_BAUD;
        r.wdata = BAUD_DIV;
      end
      S_INIT_CTRL: begin
        r.we    = 1'b1;
        r.addr  = A_CTRL;
        r.wdata = {30'h0, RX_EN, 1'b1};
      end
      S_WRITE: begin
        r.we    = 1'b1;
        r.addr  = A_TXDATA;
        r.wdata = {24'h0, b};
      end
      default: ;
    endcase
    return r;
  endfunction

  // First valid requester after last, wrapping; the one just served ranks lowest.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] last);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && v[IW'(idx)]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [7:0] data_of(input logic [8*NREQ-1:0] d, input logic [IW-1:0] g);
    logic [8*NREQ-1:0] sh;
    sh = d >> {g, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] g);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << g;
  endfunction

  assign pick      = rr_pick(req_valid_i, last_grant);
  assign pick_byte = data_of(req_data_i, pick);

  assign uart_we_o    = bus_q.we;
  assign uart_addr_o  = bus_q.addr;
  assign uart_wdata_o = bus_q.wdata;
  assign busy_o       = bus_q.busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT_BAUD;
      bus_q       <= bus_for(S_INIT_BAUD, 8'h00);
      req_ready_o <= '0;
      grant       <= '0;
      last_grant  <= IW'(NREQ - 1);
      byte_q      <= 8'h00;
      tx_count_o  <= 16'h0;
    end else begin
      req_ready_o <= '0;
      case (state)
        S_INIT_BAUD: begin
          state <= S_INIT_CTRL;
          bus_q <= bus_for(S_INIT_CTRL, byte_q);
        end
        S_INIT_CTRL: begin
          state <= S_IDLE;
          bus_q <= bus_for(S_IDLE, byte_q);
        end
        S_IDLE: begin
          if (|req_valid_i) begin
            grant  <= pick;
            byte_q <= pick_byte;
            state  <= S_POLL;
            bus_q  <= bus_for(S_POLL, pick_byte);
          end
        end
        S_POLL: begin
          if (tmo_hit) begin
            state       <= S_ACK;
            bus_q       <= bus_for(S_ACK, byte_q);
            req_ready_o <= onehot(grant);
          end else if (!uart_rdata_i[0]) begin
            state <= S_WRITE;
            bus_q <= bus_for(S_WRITE, byte_q);
          end
        end
        S_WRITE: begin
          if (tmo_hit) begin
            state       <= S_ACK;
            bus_q       <= bus_for(S_ACK, byte_q);
            req_ready_o <= onehot(grant);
          end else begin
            state <= S_CONFIRM;
            bus_q <= bus_for(S_CONFIRM, byte_q);
          end
        end
        S_CONFIRM: begin
          // STATUS.busy right after the write is the UART's acceptance of the byte.
          if (tmo_hit) begin
            state       <= S_ACK;
            bus_q       <= bus_for(S_ACK, byte_q);
            req_ready_o <= onehot(grant);
          end else if (uart_rdata_i[0]) begin
            state       <= S_ACK;
            bus_q       <= bus_for(S_ACK, byte_q);
            req_ready_o <= onehot(grant);
            tx_count_o  <= tx_count_o + 16'd1;
          end else begin
            state <= S_WRITE;
            bus_q <= bus_for(S_WRITE, byte_q);
          end
        end
        S_ACK: begin
          last_grant <= grant;
          state      <= S_IDLE;
          bus_q      <= bus_for(S_IDLE, byte_q);
        end
        default: begin
          state <= S_INIT_BAUD;
          bus_q <= bus_for(S_INIT_BAUD, byte_q);
        end
      endcase
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_q;
  logic        in_xfer;
  logic        unused_ok;

  assign in_xfer = (state == S_POLL) || (state == S_WRITE) || (state == S_CONFIRM);
  assign tmo_hit = in_xfer && (tmo_cnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE)
        tmo_cnt <= 16'h0;
      else if (in_xfer)
        tmo_cnt <= tmo_cnt + 16'd1;
      // a fresh timeout outranks a clear in the same cycle
      if (tmo_hit)
        err_q <= 1'b1;
      else if (err_clr_i)
        err_q <= 1'b0;
    end
  end

  assign err_o     = err_q;
  assign unused_ok = &{1'b0, uart_rdata_i[31:1]};
`else
  logic unused_ok;

  assign tmo_hit   = 1'b0;
  assign err_o     = 1'b0;
  assign unused_ok = &{1'b0, err_clr_i, uart_rdata_i[31:1], TIMEOUT};
`endif

endmodule
